// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
//   Three-port arbiter in front of a single-outstanding SDRAM controller.
//   Port 0 (video refill) has priority. Ports 1 (CPU) and 2 (DMA/audio) share
//   round-robin. A starvation counter limits how many port-0 grants in a row
//   can be made while port 1 or 2 is waiting.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   req_valid_i/we_i    per-port request valid / write enable (3 bits)
//   req_addr_i          packed per-port addresses, port 0 in the low slice
//   req_wdata_i         packed per-port write data
//   req_wmask_i         packed per-port byte masks
//   req_ready_o         per-port accept pulse (combinational from IDLE+valid)
//   rsp_valid_o         per-port completion pulse
//   rsp_rdata_o         read data, valid with rsp_valid_o
//   mem_*_o             command to the SDRAM controller
//   mem_ready_i         controller accepts the command
//   mem_ack_i/rdata_i   controller completion and read data
//   busy_o              high whenever the FSM is not IDLE
//   grant_o             port index owning the current transaction
// -----------------------------------------------------------------------------
module sdram_arbiter #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [2:0]              req_valid_i,
  input  logic [2:0]              req_we_i,
  input  logic [3*ADDR_W-1:0]     req_addr_i,
  input  logic [3*DATA_W-1:0]     req_wdata_i,
  input  logic [3*(DATA_W/8)-1:0] req_wmask_i,
  output logic [2:0]              req_ready_o,
  output logic [2:0]              rsp_valid_o,
  output logic [DATA_W-1:0]       rsp_rdata_o,
  output logic                    mem_valid_o,
  output logic                    mem_we_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic [DATA_W-1:0]       mem_wdata_o,
  output logic [DATA_W/8-1:0]     mem_wmask_o,
  input  logic                    mem_ready_i,
  input  logic                    mem_ack_i,
  input  logic [DATA_W-1:0]       mem_rdata_i,
  output logic                    busy_o,
  output logic [1:0]              grant_o
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_e;

  state_e              state_q, state_d;
  logic                rr_ptr_q, rr_ptr_d;        // 0 -> port 1 next, 1 -> port 2 next
  logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
  logic                cmd_we_q;
  logic [ADDR_W-1:0]   cmd_addr_q;
  logic [DATA_W-1:0]   cmd_wdata_q;
  logic [MASK_W-1:0]   cmd_wmask_q;
  logic [1:0]          grant_q;
  logic                mem_valid_q, mem_valid_d;
  logic                busy_q, busy_d;
  logic [2:0]          rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic                p12_s;
  logic                starve_s;
  logic                accept_s;
  logic [1:0]          rr_port_s;
  logic [1:0]          win_s;
  logic                sel_we_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_wdata_s;
  logic [MASK_W-1:0]   sel_wmask_s;

  assign p12_s    = req_valid_i[1] | req_valid_i[2];
  assign starve_s = p12_s && (starve_cnt_q == CNT_W'(STARVE_MAX));
  assign accept_s = (state_q == IDLE) && (|req_valid_i);

  // Winner selection: port 0 first unless starving ports 1/2, else round-robin
  always_comb begin
    rr_port_s = 2'd1;
    win_s     = 2'd0;
    if (req_valid_i[1] && req_valid_i[2]) begin
      rr_port_s = rr_ptr_q ? 2'd2 : 2'd1;
    end else if (req_valid_i[2]) begin
      rr_port_s = 2'd2;
    end else begin
      rr_port_s = 2'd1;
    end
    if (req_valid_i[0] && !starve_s) begin
      win_s = 2'd0;
    end else if (p12_s) begin
      win_s = rr_port_s;
    end else begin
      win_s = 2'd0;
    end
  end

  // Multiplex the winning port's command fields
  always_comb begin
    sel_we_s    = req_we_i[0];
    sel_addr_s  = req_addr_i[ADDR_W-1:0];
    sel_wdata_s = req_wdata_i[DATA_W-1:0];
    sel_wmask_s = req_wmask_i[MASK_W-1:0];
    case (win_s)
      2'd1: begin
        sel_we_s    = req_we_i[1];
        sel_addr_s  = req_addr_i[2*ADDR_W-1:ADDR_W];
        sel_wdata_s = req_wdata_i[2*DATA_W-1:DATA_W];
        sel_wmask_s = req_wmask_i[2*MASK_W-1:MASK_W];
      end
      2'd2: begin
        sel_we_s    = req_we_i[2];
        sel_addr_s  = req_addr_i[3*ADDR_W-1:2*ADDR_W];
        sel_wdata_s = req_wdata_i[3*DATA_W-1:2*DATA_W];
        sel_wmask_s = req_wmask_i[3*MASK_W-1:2*MASK_W];
      end
      default: begin
        sel_we_s    = req_we_i[0];
        sel_addr_s  = req_addr_i[ADDR_W-1:0];
        sel_wdata_s = req_wdata_i[DATA_W-1:0];
        sel_wmask_s = req_wmask_i[MASK_W-1:0];
      end
    endcase
  end

  // Round-robin pointer and starvation counter next-state
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    starve_cnt_d = starve_cnt_q;
    if (accept_s && (win_s == 2'd1)) begin
      rr_ptr_d = 1'b1;
    end else if (accept_s && (win_s == 2'd2)) begin
      rr_ptr_d = 1'b0;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    // Nobody waiting on 1/2 means nobody is being starved
    if (!p12_s) begin
      starve_cnt_d = {CNT_W{1'b0}};
    end else if (accept_s && (win_s == 2'd0)) begin
      if (starve_cnt_q != CNT_W'(STARVE_MAX)) begin
        starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end else begin
        starve_cnt_d = starve_cnt_q;
      end
    end else if (accept_s) begin
      starve_cnt_d = {CNT_W{1'b0}};
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_s)    state_d = ISSUE; else state_d = IDLE;
      ISSUE:   if (mem_ready_i) state_d = WAIT;  else state_d = ISSUE;
      WAIT:    if (mem_ack_i)   state_d = IDLE;  else state_d = WAIT;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: accept pulse plus next values of the registered outputs
  always_comb begin
    req_ready_o = 3'b000;
    rsp_valid_d = 3'b000;
    rsp_rdata_d = rsp_rdata_q;
    mem_valid_d = (state_d == ISSUE);
    busy_d      = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          req_ready_o = 3'b001 << win_s;
        end else begin
          req_ready_o = 3'b000;
        end
      end
      WAIT: begin
        if (mem_ack_i) begin
          rsp_valid_d = 3'b001 << grant_q;
          rsp_rdata_d = mem_rdata_i;
        end else begin
          rsp_valid_d = 3'b000;
        end
      end
      default: begin
        req_ready_o = 3'b000;
      end
    endcase
  end

  // Arbitration state, latched command and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q     <= 1'b0;
      starve_cnt_q <= {CNT_W{1'b0}};
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= {ADDR_W{1'b0}};
      cmd_wdata_q  <= {DATA_W{1'b0}};
      cmd_wmask_q  <= {MASK_W{1'b0}};
      grant_q      <= 2'd0;
      mem_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      rsp_valid_q  <= 3'b000;
      rsp_rdata_q  <= {DATA_W{1'b0}};
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      mem_valid_q  <= mem_valid_d;
      busy_q       <= busy_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      if (accept_s) begin
        cmd_we_q    <= sel_we_s;
        cmd_addr_q  <= sel_addr_s;
        cmd_wdata_q <= sel_wdata_s;
        cmd_wmask_q <= sel_wmask_s;
        grant_q     <= win_s;
      end
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign mem_valid_o = mem_valid_q;
  assign mem_we_o    = cmd_we_q;
  assign mem_addr_o  = cmd_addr_q;
  assign mem_wdata_o = cmd_wdata_q;
  assign mem_wmask_o = cmd_wmask_q;
  assign busy_o      = busy_q;
  assign grant_o     = grant_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter
//   Directed bench for sdram_arbiter with default parameters. Each port has a
//   fixed set of command fields; expected grants, fields and responses are
//   hand-derived from the arbitration rules.
// -----------------------------------------------------------------------------
module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  req_valid_i;
  logic [2:0]  req_we_i;
  logic [71:0] req_addr_i;
  logic [95:0] req_wdata_i;
  logic [11:0] req_wmask_i;
  logic [2:0]  req_ready_o;
  logic [2:0]  rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        mem_valid_o;
  logic        mem_we_o;
  logic [23:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic        mem_ready_i;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o;
  logic [1:0]  grant_o;

  logic [23:0] paddr  [3];
  logic [31:0] pwdata [3];
  logic [3:0]  pwmask [3];
  logic        pwe    [3];

  int n_checks = 0;
  int n_fail   = 0;

  sdram_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid_i (req_valid_i),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_wmask_i (req_wmask_i),
    .req_ready_o (req_ready_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .mem_valid_o (mem_valid_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_wmask_o (mem_wmask_o),
    .mem_ready_i (mem_ready_i),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .busy_o      (busy_o),
    .grant_o     (grant_o)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_fields;
    req_addr_i  = {paddr[2], paddr[1], paddr[0]};
    req_wdata_i = {pwdata[2], pwdata[1], pwdata[0]};
    req_wmask_i = {pwmask[2], pwmask[1], pwmask[0]};
    req_we_i    = {pwe[2], pwe[1], pwe[0]};
  endtask

  task automatic do_reset;
    reset_n     = 1'b0;
    req_valid_i = 3'b000;
    mem_ready_i = 1'b0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    tick;
    tick;
    reset_n = 1'b1;
  endtask

  // One full transaction starting in IDLE: accept, issue, wait, respond.
  task automatic txn(input string tag, input logic [1:0] port, input bit drop, input logic [31:0] rd);
    logic [2:0] oh;
    oh = 3'b001 << port;
    #1;
    check_eq({tag, ".ready"}, 64'(req_ready_o), 64'(oh));
    tick;
    if (drop) req_valid_i = req_valid_i & ~oh;
    check_eq({tag, ".grant"}, 64'(grant_o), 64'(port));
    check_eq({tag, ".mvalid"}, 64'(mem_valid_o), 64'(1'b1));
    check_eq({tag, ".busy"}, 64'(busy_o), 64'(1'b1));
    check_eq({tag, ".we"}, 64'(mem_we_o), 64'(pwe[port]));
    check_eq({tag, ".addr"}, 64'(mem_addr_o), 64'(paddr[port]));
    check_eq({tag, ".wdata"}, 64'(mem_wdata_o), 64'(pwdata[port]));
    check_eq({tag, ".wmask"}, 64'(mem_wmask_o), 64'(pwmask[port]));
    check_eq({tag, ".noready"}, 64'(req_ready_o), 64'(3'b000));
    mem_ready_i = 1'b1;
    tick;
    mem_ready_i = 1'b0;
    check_eq({tag, ".mvalid_off"}, 64'(mem_valid_o), 64'(1'b0));
    tick;
    mem_ack_i   = 1'b1;
    mem_rdata_i = rd;
    check_eq({tag, ".norsp"}, 64'(rsp_valid_o), 64'(3'b000));
    tick;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    check_eq({tag, ".rsp"}, 64'(rsp_valid_o), 64'(oh));
    check_eq({tag, ".idle"}, 64'(busy_o), 64'(1'b0));
    if (!pwe[port]) check_eq({tag, ".rdata"}, 64'(rsp_rdata_o), 64'(rd));
  endtask

  initial begin
    logic [1:0]  starve_seq [10];
    logic [23:0] hold_addr;

    paddr[0]  = 24'h000A00; paddr[1]  = 24'h000100; paddr[2]  = 24'h000200;
    pwdata[0] = 32'h11111111; pwdata[1] = 32'h22222222; pwdata[2] = 32'h33333333;
    pwmask[0] = 4'hF; pwmask[1] = 4'hF; pwmask[2] = 4'b0101;
    pwe[0] = 1'b0; pwe[1] = 1'b0; pwe[2] = 1'b0;
    load_fields;

    // Reset values
    reset_n     = 1'b0;
    req_valid_i = 3'b000;
    mem_ready_i = 1'b0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    #1;
    check_eq("rst.mvalid", 64'(mem_valid_o), 64'(1'b0));
    check_eq("rst.busy", 64'(busy_o), 64'(1'b0));
    check_eq("rst.grant", 64'(grant_o), 64'(2'd0));
    check_eq("rst.rsp", 64'(rsp_valid_o), 64'(3'b000));
    check_eq("rst.ready", 64'(req_ready_o), 64'(3'b000));
    check_eq("rst.addr", 64'(mem_addr_o), 64'(24'h0));
    do_reset;

    // Single port-1 read
    req_valid_i = 3'b010;
    txn("p1_read", 2'd1, 1'b1, 32'hDEADBEEF);

    // Three-way contention: port 0 first, then 1/2 alternate across rounds
    do_reset;
    req_valid_i = 3'b110;
    for (int r = 0; r < 3; r++) begin
      req_valid_i[0] = 1'b1;
      txn("rr.p0", 2'd0, 1'b1, 32'hA0000000 + 32'(r));
      txn("rr.p12", (r % 2 == 0) ? 2'd1 : 2'd2, 1'b0, 32'hB0000000 + 32'(r));
    end

    // Starvation limit: four port-0 grants, then one port-2 grant, repeated
    do_reset;
    starve_seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2};
    req_valid_i = 3'b101;
    for (int i = 0; i < 10; i++) begin
      txn("starve", starve_seq[i], 1'b0, 32'hC0000000 + 32'(i));
    end

    // Controller back-pressure: command held stable, no new accepts, ack ignored in ISSUE
    do_reset;
    req_valid_i = 3'b001;
    #1;
    check_eq("bp.ready", 64'(req_ready_o), 64'(3'b001));
    tick;
    hold_addr   = paddr[0];
    req_valid_i = 3'b010;
    req_addr_i  = ~req_addr_i;
    for (int i = 0; i < 10; i++) begin
      check_eq("bp.mvalid", 64'(mem_valid_o), 64'(1'b1));
      check_eq("bp.addr", 64'(mem_addr_o), 64'(hold_addr));
      check_eq("bp.noready", 64'(req_ready_o), 64'(3'b000));
      check_eq("bp.norsp", 64'(rsp_valid_o), 64'(3'b000));
      mem_ack_i = (i == 4);
      tick;
    end
    mem_ack_i = 1'b0;
    load_fields;
    mem_ready_i = 1'b1;
    tick;
    mem_ready_i = 1'b0;
    tick;
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h5A5A5A5A;
    tick;
    mem_ack_i   = 1'b0;
    #1;
    check_eq("bp.rsp", 64'(rsp_valid_o), 64'(3'b001));
    check_eq("bp.rdata", 64'(rsp_rdata_o), 64'(32'h5A5A5A5A));
    check_eq("bp.next_accept", 64'(req_ready_o), 64'(3'b010));

    // Reset in WAIT, then a stray ack after release
    do_reset;
    req_valid_i = 3'b010;
    #1;
    tick;
    req_valid_i = 3'b000;
    mem_ready_i = 1'b1;
    tick;
    mem_ready_i = 1'b0;
    check_eq("rw.busy", 64'(busy_o), 64'(1'b1));
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rw.mvalid", 64'(mem_valid_o), 64'(1'b0));
    check_eq("rw.busy0", 64'(busy_o), 64'(1'b0));
    check_eq("rw.grant", 64'(grant_o), 64'(2'd0));
    check_eq("rw.addr", 64'(mem_addr_o), 64'(24'h0));
    check_eq("rw.rsp", 64'(rsp_valid_o), 64'(3'b000));
    tick;
    reset_n     = 1'b1;
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hBADBAD00;
    tick;
    mem_ack_i = 1'b0;
    check_eq("rw.stray_rsp", 64'(rsp_valid_o), 64'(3'b000));
    check_eq("rw.stray_busy", 64'(busy_o), 64'(1'b0));
    tick;
    check_eq("rw.stray_rsp2", 64'(rsp_valid_o), 64'(3'b000));
    req_valid_i = 3'b110;
    txn("rw.ptr", 2'd1, 1'b1, 32'h01010101);
    txn("rw.p2", 2'd2, 1'b1, 32'h02020202);

    // Port-2 masked write
    do_reset;
    pwe[2] = 1'b1;
    load_fields;
    req_valid_i = 3'b100;
    txn("p2_write", 2'd2, 1'b1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
